// File: rtl/mul_repadd_unit.sv
// mul_repadd_unit: sequential unsigned multiplier, P = A added B times.
//
// The operand registers, adder, B-decrementer, zero detect and the FSM
// controller all live in this one block. Operands arrive serially on
// data_in: A in the cycle after start is accepted, B in the next one.
//
// Optional feature: define MUL_OVF_EN to build the sticky overflow flag.
// Without it, ovf is tied low and no carry logic is compiled.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (aborts any operation)
//   start        level request, sampled only in IDLE and DONE
//   data_in      shared operand bus (A, then B)
//   product      P register, straight from the flop
//   done         high while in DONE
//   busy         high in LOAD_A, LOAD_B and ADD
//   ovf          sticky overflow flag (0 unless MUL_OVF_EN)
//   dbg_state_o  current FSM state, for checkers
//
// Handshake: the host raises start in IDLE, drives A then B on the next
// two cycles, and holds start until it sees done. The result is valid
// while done=1. The unit returns to IDLE on the first edge where start=0
// in DONE, so back-to-back jobs need start low for at least one edge.
module mul_repadd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic             done_q;
  logic             busy_q;

  logic             eqz;
  logic [WIDTH-1:0] b_dec_d;

  assign eqz     = (b_q == '0);
  assign b_dec_d = b_q - WIDTH'(1);

`ifdef MUL_OVF_EN
  // One extra bit catches the carry out of the top bit of P+A.
  logic [WIDTH:0] sum_d;
  logic           ovf_q;
  assign sum_d = {1'b0, p_q} + {1'b0, a_q};
`else
  logic [WIDTH-1:0] sum_d;
  assign sum_d = p_q + a_q;
`endif

  // done/busy are registered alongside the state so they never see a
  // combinational path from start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD_A;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD_A: begin
          a_q     <= data_in;
          state_q <= S_LOAD_B;
        end
        S_LOAD_B: begin
          b_q     <= data_in;
          p_q     <= '0;
`ifdef MUL_OVF_EN
          ovf_q   <= 1'b0;
`endif
          state_q <= S_ADD;
        end
        S_ADD: begin
          // B counts down to zero; each nonzero B adds one more copy of A.
          if (!eqz) begin
            p_q <= sum_d[WIDTH-1:0];
            b_q <= b_dec_d;
`ifdef MUL_OVF_EN
            if (sum_d[WIDTH]) ovf_q <= 1'b1;
`endif
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product     = p_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

`ifdef MUL_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul_repadd_unit.sv
// Bench for mul_repadd_unit: directed cases with literal results plus
// randomized jobs, checked against an arithmetic model (A*B mod 2^W,
// overflow when A*B >= 2^W, done after edge B+4).
module tb_mul_repadd_unit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] product;
  logic         done;
  logic         busy;
  logic         ovf;
  logic [2:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

`ifdef MUL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  mul_repadd_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .product     (product),
    .done        (done),
    .busy        (busy),
    .ovf         (ovf),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare process ----------------
  // While done is high, product and ovf must match the head expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1, expected no job pending");
      end else begin
        chk("sb_product", 32'(product), 32'(exp_q[0]));
        chk("sb_ovf", 32'(ovf), 32'(exp_ovf_q[0]));
      end
    end
  end

  // ---------------- driver ----------------
  // One complete job. Edge k counts from the edge that samples start.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit has_lit, input logic [W-1:0] lit);
    longint unsigned full;
    int lat;
    full = longint'(a) * longint'(b);
    exp_q.push_back(full[W-1:0]);
    exp_ovf_q.push_back(OVF_EN && (full >= (64'd1 << W)));
    lat = int'(b) + 4;

    @(negedge clk);
    start   = 1'b1;
    data_in = W'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("busy_timing", 32'(busy), 32'(k <= lat - 1));
      chk("done_timing", 32'(done), 32'(k == lat));
      if (k == 1)      data_in = a;
      else if (k == 2) data_in = b;
      else             data_in = W'($urandom);
    end
    if (has_lit) chk("lit_product", 32'(product), 32'(lit));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("drop_done", 32'(done), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    void'(exp_q.pop_front());
    void'(exp_ovf_q.pop_front());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Start ignored data_in while idle with start low.
    data_in = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed cases with hand-computed results.
    run_mul(16'd17, 16'd5, 3, 1'b1, 16'd85);
    run_mul(16'd17, 16'd0, 1, 1'b1, 16'd0);
    run_mul(16'd0,  16'd7, 0, 1'b1, 16'd0);
    run_mul(16'd300, 16'd300, 2, 1'b1, 16'd24464);
    chk("ovf_300x300_model", 32'(exp_ovf_q.size()), 32'd0);

    // Reset in the middle of ADD aborts the job.
    @(negedge clk);
    start   = 1'b1;
    @(negedge clk);
    data_in = 16'd1000;
    @(negedge clk);
    data_in = 16'd1000;
    repeat (20) @(negedge clk);
    chk("midop_busy", 32'(busy), 32'd1);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    run_mul(16'd3, 16'd4, 1, 1'b1, 16'd12);

    // Handshake: held start, drop, re-raise.
    run_mul(16'd6, 16'd7, 4, 1'b1, 16'd42);

    // Randomized jobs; large A with small B exercises wrap and overflow.
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 50));
      rb = W'($urandom_range(0, 30));
      run_mul(ra, rb, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_repadd_unit.md
Name: mul_repadd_unit

Overview:
- Sequential unsigned multiplier that multiplies by repeated addition: P = A added B times.
- Integrates the operand/product datapath (A, B, P registers, adder, B-decrementer, zero detect) with its FSM controller in one block.
- Both operands arrive serially on a shared data_in bus: first A, then B.
- Sits as a small arithmetic slave.
  - The host raises start, drives the two operands in consecutive cycles, then waits for done.

Parameters:
- WIDTH, 16: width of data_in, A, B and the product register P.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  level request; sampled in IDLE.
- data_in  input  WIDTH  shared operand bus (A then B).
- product  output  WIDTH  P register, driven directly from the flop.
- done  output  1  high while FSM is in DONE.
- busy  output  1  high in LOAD_A, LOAD_B and ADD.
- ovf  output  1  overflow flag (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On rst at a rising edge: state=IDLE, A=0, B=0, P=0, ovf=0, done=0, busy=0.
  - Reset overrides everything, including mid-operation; the operation is aborted with no partial result kept.
- IDLE:
  - start=1 at an edge -> LOAD_A. Otherwise stay.
  - data_in is ignored.
- LOAD_A: at the exiting edge, A<=data_in; -> LOAD_B.
- LOAD_B:
  - At the exiting edge: B<=data_in, P<=0, ovf<=0; -> ADD.
- ADD: each edge, with eqz = (B==0) evaluated combinationally on the current B:
  - eqz=0: P<=P+A (modulo 2^WIDTH), B<=B-1; stay in ADD.
  - eqz=1: no update; -> DONE.
- DONE:
  - done=1; product is held stable.
  - Stay while start=1. start=0 at an edge -> IDLE.
  - A new multiply therefore needs start low for at least one edge, then high again.
- Latency:
  - Counting the edge that samples start as edge 1, done rises after edge B+4.
  - Examples: B=5 -> edge 9; B=0 -> edge 4.
- Arithmetic: unsigned; P wraps modulo 2^WIDTH; A is never modified during ADD.
- Output and flag rules:
  - done and busy are decoded from registered state only; no combinational path from start.
  - product is valid only while done=1. Intermediate P values are visible during ADD but carry no meaning.
  - start changes outside IDLE/DONE are ignored.

Optional Feature:
- Macro MUL_OVF_EN.
- Defined:
  - ovf is a sticky register, cleared in LOAD_B.
  - It is set at any ADD edge where the P+A addition carries out of bit WIDTH-1.
  - It holds through DONE until the next LOAD_B or reset.
- Undefined: ovf is tied to 0 and the carry logic is not compiled; the port remains present.

Test Plan:
- Basic multiply:
  - Stimulus: reset 2 cycles; start=1; data_in=17 during LOAD_A, 5 during LOAD_B.
  - Response: done rises after edge 9; product=85; ovf=0; done stays high while start held.
- Zero operands:
  - 17x0 -> product=0, done after edge 4.
  - 0x7 -> product=0, done after edge 11.
- Overflow (MUL_OVF_EN defined):
  - 300x300 -> product=24464 (90000 mod 65536), ovf=1.
  - Without the macro: same product, ovf=0.
- Reset mid-operation:
  - Stimulus: 1000x1000; assert rst during ADD.
  - Response: next edge state=IDLE, P=0, done=0, busy=0.
  - A following 3x4 run gives 12.
- Handshake:
  - Hold start=1 after DONE -> no restart and product holds.
  - Drop start -> IDLE at the next edge, done=0.
  - Raise start again with 6 and 7 -> product=42.
